hack_control: RTL and testbench

Multi-cycle control unit for the Hack CPU: it drives the ALU's six control bits and operands and consumes the ALU's `zo`/`ng` flags. It fetches 16-bit Hack instructions and holds the architectural A, D and PC registers. It sequences data-memory reads and writes over a valid/ack handshake, then evaluates jump conditions. It sits between instruction ROM, data RAM and the combinational `alu`.

---
 rtl/hack_control.sv | 141 ++++++++++++++
 tb/tb_hack_control.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_control.sv
// Multi-cycle Hack CPU control unit: fetches instructions, holds A/D/PC, drives the
// external combinational ALU and sequences data-memory reads/writes over valid/ack.
module hack_control (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    output logic [14:0] instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        c1,
    output logic        c2,
    output logic        c3,
    output logic        c4,
    output logic        c5,
    output logic        c6,
    input  logic [15:0] alu_out,
    input  logic        alu_zo,
    input  logic        alu_ng
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        EXEC   = 3'd3,
        MEMWR  = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [14:0] pc_reg;
    logic [14:0] aold_reg;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] ir_reg;
    logic [15:0] m_reg;
    logic [15:0] r_reg;
    logic        instr_req_reg;
    logic        mem_rd_reg;
    logic        mem_wr_reg;

    logic [14:0] pc_inc;
    logic        jump_taken;

    assign pc_inc     = pc_reg + 15'd1;
    assign jump_taken = (ir_reg[2] & alu_ng)
                      | (ir_reg[1] & alu_zo)
                      | (ir_reg[0] & ~alu_zo & ~alu_ng);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (instr_valid) state_next = DECODE;
            end
            DECODE: begin
                if (!ir_reg[15])     state_next = FETCH;
                else if (ir_reg[12]) state_next = MEMRD;
                else                 state_next = EXEC;
            end
            MEMRD: begin
                if (mem_ack) state_next = EXEC;
            end
            EXEC: begin
                state_next = ir_reg[3] ? MEMWR : FETCH;
            end
            MEMWR: begin
                if (mem_ack) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Strobes are flopped from the next state so they come straight out of registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= FETCH;
            pc_reg        <= '0;
            aold_reg      <= '0;
            a_reg         <= '0;
            d_reg         <= '0;
            ir_reg        <= '0;
            m_reg         <= '0;
            r_reg         <= '0;
            instr_req_reg <= 1'b1;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            instr_req_reg <= (state_next == FETCH);
            mem_rd_reg    <= (state_next == MEMRD);
            mem_wr_reg    <= (state_next == MEMWR);
            case (state_reg)
                FETCH: begin
                    if (instr_valid) ir_reg <= instr;
                end
                DECODE: begin
                    if (!ir_reg[15]) begin
                        a_reg  <= ir_reg;
                        pc_reg <= pc_inc;
                    end else begin
                        aold_reg <= a_reg[14:0];
                    end
                end
                MEMRD: begin
                    if (mem_ack) m_reg <= mem_rdata;
                end
                EXEC: begin
                    r_reg <= alu_out;
                    if (ir_reg[5]) a_reg <= alu_out;
                    if (ir_reg[4]) d_reg <= alu_out;
                    pc_reg <= jump_taken ? aold_reg : pc_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign instr_req  = instr_req_reg;
    assign mem_rd     = mem_rd_reg;
    assign mem_wr     = mem_wr_reg;
    assign instr_addr = pc_reg;

    // Writes go to the address A held before this instruction, even if dest includes A.
    assign mem_addr   = mem_wr_reg ? aold_reg : a_reg[14:0];
    assign mem_wdata  = r_reg;

    assign alu_x = d_reg;
    assign alu_y = ir_reg[12] ? m_reg : a_reg;
    assign {c1, c2, c3, c4, c5, c6} = ir_reg[11:6];

endmodule

// File: tb/tb_hack_control.sv
// Self-checking bench for hack_control: directed vector table, a reset-mid-write
// sequence and random programs checked against an instruction-level Hack model.
module tb_hack_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic        mem_rd;
    logic        mem_wr;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        c1, c2, c3, c4, c5, c6;
    logic [15:0] alu_out;
    logic        alu_zo;
    logic        alu_ng;

    always #5 clk = ~clk;

    hack_control dut (
        .clk        (clk),
        .reset      (reset),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr      (instr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .c5         (c5),
        .c6         (c6),
        .alu_out    (alu_out),
        .alu_zo     (alu_zo),
        .alu_ng     (alu_ng)
    );

    // Standard Hack ALU, acting as the external combinational device.
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, {c1, c2, c3, c4, c5, c6});
    assign alu_zo  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction-level reference state and the two memory images.
    logic [14:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [15:0] ram  [0:32767];
    logic [15:0] mram [0:32767];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_strobes(input string name, input logic [2:0] exp);
        chk(name, 32'({instr_req, mem_rd, mem_wr}), 32'(exp));
    endtask

    // Drives one instruction through the DUT with the given handshake waits and
    // checks every cycle against the instruction-level model.
    task automatic run_instr(input logic [15:0] ins, input int wf, input int wm);
        logic [15:0] y;
        logic [15:0] res;
        logic [15:0] aold;
        logic        jmp;
        aold = m_a;
        chk("fetch_addr", 32'(instr_addr), 32'(m_pc));
        for (int i = 0; i < wf; i++) begin
            chk_strobes("fetch_wait", 3'b100);
            instr_valid = 1'b0;
            instr       = 16'($urandom);
            mem_ack     = 1'($urandom);
            mem_rdata   = 16'($urandom);
            @(negedge clk);
        end
        chk_strobes("fetch", 3'b100);
        instr_valid = 1'b1;
        instr       = ins;
        mem_ack     = 1'($urandom);
        @(negedge clk);
        chk_strobes("decode", 3'b000);
        instr_valid = 1'($urandom);
        instr       = 16'($urandom);
        mem_ack     = 1'($urandom);
        @(negedge clk);
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            if (ins[12]) begin
                for (int i = 0; i <= wm; i++) begin
                    chk_strobes("memrd", 3'b010);
                    chk("rd_addr", 32'(mem_addr), 32'(m_a[14:0]));
                    instr_valid = 1'($urandom);
                    instr       = 16'($urandom);
                    mem_ack     = (i == wm);
                    mem_rdata   = (i == wm) ? ram[mem_addr] : 16'($urandom);
                    @(negedge clk);
                end
                y = mram[m_a[14:0]];
            end else begin
                y = m_a;
            end
            res = hack_alu(m_d, y, ins[11:6]);
            chk_strobes("exec", 3'b000);
            chk("ctrl", 32'({c1, c2, c3, c4, c5, c6}), 32'(ins[11:6]));
            chk("alu_x", 32'(alu_x), 32'(m_d));
            chk("alu_y", 32'(alu_y), 32'(y));
            instr_valid = 1'($urandom);
            mem_ack     = 1'($urandom);
            mem_rdata   = 16'($urandom);
            @(negedge clk);
            jmp = (ins[2] && res[15]) || (ins[1] && res == 16'h0000)
               || (ins[0] && res != 16'h0000 && !res[15]);
            if (ins[3]) begin
                for (int i = 0; i <= wm; i++) begin
                    chk_strobes("memwr", 3'b001);
                    chk("wr_addr", 32'(mem_addr), 32'(aold[14:0]));
                    chk("wr_data", 32'(mem_wdata), 32'(res));
                    instr_valid = 1'($urandom);
                    mem_ack     = (i == wm);
                    if (i == wm) ram[mem_addr] = mem_wdata;
                    @(negedge clk);
                end
                mram[aold[14:0]] = res;
            end
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            m_pc = jmp ? aold[14:0] : (m_pc + 15'd1);
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        chk_strobes("next_fetch", 3'b100);
        chk("next_pc", 32'(instr_addr), 32'(m_pc));
    endtask

    typedef struct {
        logic [15:0] ins;
        int          wf;
        int          wm;
        logic [14:0] pc;
        logic [15:0] d;
    } vec_t;

    vec_t tbl [22];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic [31:0] rr;

        tbl[0]  = '{16'h0005, 0, 0, 15'h0001, 16'h0000};
        tbl[1]  = '{16'hEC10, 2, 0, 15'h0002, 16'h0005};
        tbl[2]  = '{16'h0007, 0, 0, 15'h0003, 16'h0005};
        tbl[3]  = '{16'hEC10, 0, 0, 15'h0004, 16'h0007};
        tbl[4]  = '{16'h0020, 1, 0, 15'h0005, 16'h0007};
        tbl[5]  = '{16'hE7C8, 0, 3, 15'h0006, 16'h0007};
        tbl[6]  = '{16'h0030, 0, 0, 15'h0007, 16'h0007};
        tbl[7]  = '{16'hFC10, 0, 1, 15'h0008, 16'h1234};
        tbl[8]  = '{16'h0010, 0, 0, 15'h0009, 16'h1234};
        tbl[9]  = '{16'hE301, 1, 0, 15'h0010, 16'h1234};
        tbl[10] = '{16'hEE90, 0, 0, 15'h0011, 16'hFFFF};
        tbl[11] = '{16'h0010, 0, 0, 15'h0012, 16'hFFFF};
        tbl[12] = '{16'hE301, 0, 0, 15'h0013, 16'hFFFF};
        tbl[13] = '{16'hEA87, 0, 0, 15'h0010, 16'hFFFF};
        tbl[14] = '{16'h0040, 0, 0, 15'h0011, 16'hFFFF};
        tbl[15] = '{16'hFCA8, 0, 2, 15'h0012, 16'hFFFF};
        tbl[16] = '{16'hEC10, 0, 0, 15'h0013, 16'h00FF};
        tbl[17] = '{16'h0040, 0, 0, 15'h0014, 16'h00FF};
        tbl[18] = '{16'hFC10, 0, 0, 15'h0015, 16'h00FF};
        tbl[19] = '{16'h7FFF, 0, 0, 15'h0016, 16'h00FF};
        tbl[20] = '{16'hEA87, 0, 0, 15'h7FFF, 16'h00FF};
        tbl[21] = '{16'h0003, 0, 0, 15'h0000, 16'h00FF};

        for (int i = 0; i < 32768; i++) begin
            r       = 16'($urandom);
            ram[i]  = r;
            mram[i] = r;
        end
        ram[16'h0030]  = 16'h1234;
        mram[16'h0030] = 16'h1234;
        ram[16'h0040]  = 16'h0100;
        mram[16'h0040] = 16'h0100;

        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'hFFFF;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk_strobes("reset_strobes", 3'b100);
        chk("reset_pc", 32'(instr_addr), 32'h0);
        chk("reset_alu_x", 32'(alu_x), 32'h0);
        chk("reset_alu_y", 32'(alu_y), 32'h0);
        chk("reset_ctrl", 32'({c1, c2, c3, c4, c5, c6}), 32'h0);
        reset       = 1'b0;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;

        for (int i = 0; i < 22; i++) begin
            run_instr(tbl[i].ins, tbl[i].wf, tbl[i].wm);
            chk("tbl_pc", 32'(instr_addr), 32'(tbl[i].pc));
            chk("tbl_d", 32'(alu_x), 32'(tbl[i].d));
            $display("vec %0d: instr=0x%04h pc=0x%04h d=0x%04h", i, tbl[i].ins, instr_addr, alu_x);
        end

        // Reset while a write is still waiting for its ack; the late ack must be ignored.
        run_instr(16'h0050, 0, 0);
        instr_valid = 1'b1;
        instr       = 16'hE7C8;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk_strobes("rst_exec", 3'b000);
        @(negedge clk);
        chk_strobes("rst_memwr", 3'b001);
        chk("rst_wr_addr", 32'(mem_addr), 32'h50);
        @(negedge clk);
        chk_strobes("rst_memwr_wait", 3'b001);
        reset = 1'b1;
        @(negedge clk);
        chk_strobes("rst_drop", 3'b100);
        chk("rst_pc", 32'(instr_addr), 32'h0);
        chk("rst_d", 32'(alu_x), 32'h0);
        reset   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk_strobes("rst_late_ack", 3'b100);
        chk("rst_refetch", 32'(instr_addr), 32'h0);
        mem_ack = 1'b0;
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        $display("reset during write: strobes=%b pc=0x%04h", {instr_req, mem_rd, mem_wr}, instr_addr);

        for (int i = 0; i < 300; i++) begin
            rr = $urandom;
            r  = {rr[31], rr[14:0]};
            run_instr(r, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
            $display("rand %0d: instr=0x%04h pc=0x%04h d=0x%04h", i, r, instr_addr, alu_x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
